agc_sequencer: RTL and testbench
================================

// Module: agc_sequencer
// PURPOSE
//  Instruction sequencer and program counter for the AGC datapath.
//  Owns the PC and fetches each instruction word. Steps a Moore state machine through per-opcode micro-cycles.
//  Drives every datapath control line: alu_op, mux selects, register write enables, mem_WE.
//  Sits directly upstream of the datapath and consumes its memory output and accumulator flags.
// PARAMETERS
//  RESET_PC  12'o2000  PC value loaded on reset
//  ALU_ADD   3'd0      alu_op code for add
//  ALU_AND   3'd1      alu_op code for bitwise and
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  run            in   1   1 = execute instructions; sampled only in IDLE and at instruction end
//  mem_data       in   16  datapath memory read result (memOut)
//  acc_sign       in   1   regA[15] of datapath
//  acc_zero       in   1   1 when regA magnitude is zero (+0 or -0)
//  pc_addr        out  12  program counter; feeds datapath MAddr select 0
//  alu_op         out  3   ALU command
//  maddr_mux, a_mux, x_mux, y_mux, z_mux, q_mux  out 2 each  datapath mux selects
//  lp_mux, b_mux  out  1   datapath mux selects
//  lp_we, g_we, q_we, b_we, a_we, y_we, x_we, z_we, mem_we  out 1 each  write enables
//  busy           out  1   1 in any state other than IDLE
//  instr_done     out  1   one-cycle pulse in the last cycle of each instruction
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, IR=0. All outputs are 0 on the cycle after the reset edge.
//  This holds even when reset lands mid-instruction. No partial write is issued after reset.
//  Outputs are decoded from the state register and IR only (Moore). Any select/enable not listed for a cycle is 0.
//  IDLE: stays in IDLE while run=0. Goes to F0 when run=1.
//  F0: maddr_mux=0 (PC).
//  F1: IR<=mem_data. b_we=1, b_mux=0, so regB holds the instruction and S=address field.
//  Decode uses opcode=IR[14:12]. Execute cycles E0..En follow:
//   0 TC   : E0 pc<=IR[11:0]. Instruction ends here; no increment.
//   1 CCS  : E0 maddr=1 | E1 a_we, a_mux=0 | E2 pc<=pc+1+skip.
//            skip is computed at E2: +nonzero=0, +0=1, -nonzero=2, -0=3.
//   2 INDEX: E0 no-op (reserved this revision).
//   3 XCH  : E0 maddr=1 | E1 g_we | E2 maddr=1, mem_we | E3 a_we, a_mux=3.
//   4 CS   : E0 maddr=1 | E1 a_we, a_mux=0 | E2 a_we, a_mux=2.
//   5 TS   : E0 maddr=1, mem_we.
//   6 AD   : E0 maddr=1 | E1 x_we, x_mux=3, y_we, y_mux=0 | E2 alu_op=ALU_ADD | E3 a_we, a_mux=1.
//   7 MASK : same as AD, with alu_op=ALU_AND in E2.
//  PC update: in the last E cycle of every opcode except TC and CCS, pc<=pc+1. instr_done=1 in that same cycle.
//  PC arithmetic: PC is 12 bits and wraps modulo 4096, so 12'hFFF+1=0. A CCS skip also wraps.
//  Next state after the last E cycle: F0 if run=1, otherwise IDLE.
//   Dropping run mid-instruction never aborts it.
//  alu_op is held at ALU_ADD in every cycle other than E2. The ALU result is registered, so U is valid in E3.
//  mem_we is never asserted in the same cycle as any a_we.
// TESTING
//  1. Reset with run=1, hold 3 cycles, release.
//     -> pc_addr=1024 and all enables=0 while in reset. F0 on the first cycle after release.
//  2. TC 12'o0100 at 1024.
//     -> pc_addr=64 after 3 cycles. instr_done pulses once. No write enables asserted.
//  3. AD operand 5 with A=3 (mem[S]=5).
//     -> a_we with a_mux=1 in cycle 6 after fetch start. ALU add requested in cycle 5. pc+1.
//  4. CCS for A=+7, +0, -7 (0xFFF8), -0 (0xFFFF).
//     -> pc advances by 1, 2, 3, 4 respectively.
//  5. XCH.
//     -> g_we, mem_we and a_we (mux=3) each assert in separate consecutive cycles, in that order.
//  6. Reset asserted during AD E1.
//     -> no a_we afterward. pc=1024, state IDLE. Also check TS at pc=4095 wraps pc to 0.

Source files
------------

// File: rtl/agc_sequencer.sv
// agc_sequencer: program counter, instruction fetch and per-opcode micro-cycle
// sequencing for the AGC datapath. Every control output is a registered Moore output.
module agc_sequencer #(
    parameter logic [11:0] RESET_PC = 12'o2000,
    parameter logic [2:0]  ALU_ADD  = 3'd0,
    parameter logic [2:0]  ALU_AND  = 3'd1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [15:0] i_mem_data,
    input  logic        i_acc_sign,
    input  logic        i_acc_zero,
    output logic [11:0] o_pc_addr,
    output logic [2:0]  o_alu_op,
    output logic [1:0]  o_maddr_mux,
    output logic [1:0]  o_a_mux,
    output logic [1:0]  o_x_mux,
    output logic [1:0]  o_y_mux,
    output logic [1:0]  o_z_mux,
    output logic [1:0]  o_q_mux,
    output logic        o_lp_mux,
    output logic        o_b_mux,
    output logic        o_lp_we,
    output logic        o_g_we,
    output logic        o_q_we,
    output logic        o_b_we,
    output logic        o_a_we,
    output logic        o_y_we,
    output logic        o_x_we,
    output logic        o_z_we,
    output logic        o_mem_we,
    output logic        o_busy,
    output logic        o_instr_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_E0, S_E1, S_E2, S_E3
    } state_t;

    localparam logic [2:0] OP_TC    = 3'd0;
    localparam logic [2:0] OP_CCS   = 3'd1;
    localparam logic [2:0] OP_XCH   = 3'd3;
    localparam logic [2:0] OP_CS    = 3'd4;
    localparam logic [2:0] OP_TS    = 3'd5;
    localparam logic [2:0] OP_AD    = 3'd6;
    localparam logic [2:0] OP_MASK  = 3'd7;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] maddr_mux;
        logic [1:0] a_mux;
        logic [1:0] x_mux;
        logic [1:0] y_mux;
        logic [1:0] z_mux;
        logic [1:0] q_mux;
        logic       lp_mux;
        logic       b_mux;
        logic       lp_we;
        logic       g_we;
        logic       q_we;
        logic       b_we;
        logic       a_we;
        logic       y_we;
        logic       x_we;
        logic       z_we;
        logic       mem_we;
        logic       busy;
        logic       instr_done;
    } ctrl_t;

    state_t      r_state;
    logic [14:0] r_ir;
    logic [11:0] r_pc;
    ctrl_t       r_ctrl;

    state_t      w_nextState;
    logic [14:0] w_nextIr;
    logic [11:0] w_nextPc;
    logic [11:0] w_skip;
    logic [2:0]  w_op;
    logic [1:0]  w_eIdx;
    logic        w_inExec;
    logic        w_isLast;
    logic        w_unused;

    function automatic logic [1:0] execIndex(input state_t s);
        case (s)
            S_E1:    execIndex = 2'd1;
            S_E2:    execIndex = 2'd2;
            S_E3:    execIndex = 2'd3;
            default: execIndex = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] lastIdx(input logic [2:0] op);
        case (op)
            OP_CCS, OP_CS:          lastIdx = 2'd2;
            OP_XCH, OP_AD, OP_MASK: lastIdx = 2'd3;
            default:                lastIdx = 2'd0;
        endcase
    endfunction

    // Control word for a given state/opcode; registered one cycle ahead of use.
    function automatic ctrl_t decode(input state_t s, input logic [2:0] op);
        ctrl_t      c;
        logic [1:0] e;
        c        = '0;
        c.alu_op = ALU_ADD;
        e        = execIndex(s);
        case (s)
            S_F0: c.busy = 1'b1;
            S_F1: begin
                c.busy = 1'b1;
                c.b_we = 1'b1;
            end
            S_E0, S_E1, S_E2, S_E3: begin
                c.busy       = 1'b1;
                c.instr_done = (e == lastIdx(op));
                case (op)
                    OP_CCS: begin
                        if (e == 2'd0) c.maddr_mux = 2'd1;
                        if (e == 2'd1) c.a_we = 1'b1;
                    end
                    OP_XCH: begin
                        case (e)
                            2'd0: c.maddr_mux = 2'd1;
                            2'd1: c.g_we = 1'b1;
                            2'd2: begin
                                c.maddr_mux = 2'd1;
                                c.mem_we    = 1'b1;
                            end
                            default: begin
                                c.a_we  = 1'b1;
                                c.a_mux = 2'd3;
                            end
                        endcase
                    end
                    OP_CS: begin
                        if (e == 2'd0) c.maddr_mux = 2'd1;
                        if (e == 2'd1) c.a_we = 1'b1;
                        if (e == 2'd2) begin
                            c.a_we  = 1'b1;
                            c.a_mux = 2'd2;
                        end
                    end
                    OP_TS: begin
                        c.maddr_mux = 2'd1;
                        c.mem_we    = 1'b1;
                    end
                    OP_AD, OP_MASK: begin
                        case (e)
                            2'd0: c.maddr_mux = 2'd1;
                            2'd1: begin
                                c.x_we  = 1'b1;
                                c.x_mux = 2'd3;
                                c.y_we  = 1'b1;
                                c.y_mux = 2'd0;
                            end
                            2'd2: c.alu_op = (op == OP_MASK) ? ALU_AND : ALU_ADD;
                            default: begin
                                c.a_we  = 1'b1;
                                c.a_mux = 2'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

    assign w_unused = ^i_mem_data[15];

    always_comb begin
        w_op     = r_ir[14:12];
        w_eIdx   = execIndex(r_state);
        w_inExec = (r_state == S_E0) || (r_state == S_E1) ||
                   (r_state == S_E2) || (r_state == S_E3);
        w_isLast = w_inExec && (w_eIdx == lastIdx(w_op));
        // CCS skip: +nonzero=0, +0=1, -nonzero=2, -0=3
        w_skip   = {10'd0, i_acc_sign, i_acc_zero};
        w_nextIr = (r_state == S_F1) ? i_mem_data[14:0] : r_ir;
        w_nextPc = r_pc;
        if (w_isLast) begin
            case (w_op)
                OP_TC:   w_nextPc = r_ir[11:0];
                OP_CCS:  w_nextPc = r_pc + 12'd1 + w_skip;
                default: w_nextPc = r_pc + 12'd1;
            endcase
        end
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:  w_nextState = i_run ? S_F0 : S_IDLE;
            S_F0:    w_nextState = S_F1;
            S_F1:    w_nextState = S_E0;
            S_E0:    w_nextState = S_E1;
            S_E1:    w_nextState = S_E2;
            S_E2:    w_nextState = S_E3;
            default: w_nextState = S_IDLE;
        endcase
        if (w_isLast) w_nextState = i_run ? S_F0 : S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_ctrl  <= decode(S_IDLE, 3'd0);
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            r_ir    <= w_nextIr;
            r_ctrl  <= decode(w_nextState, w_nextIr[14:12]);
        end
    end

    assign o_pc_addr    = r_pc;
    assign o_alu_op     = r_ctrl.alu_op;
    assign o_maddr_mux  = r_ctrl.maddr_mux;
    assign o_a_mux      = r_ctrl.a_mux;
    assign o_x_mux      = r_ctrl.x_mux;
    assign o_y_mux      = r_ctrl.y_mux;
    assign o_z_mux      = r_ctrl.z_mux;
    assign o_q_mux      = r_ctrl.q_mux;
    assign o_lp_mux     = r_ctrl.lp_mux;
    assign o_b_mux      = r_ctrl.b_mux;
    assign o_lp_we      = r_ctrl.lp_we;
    assign o_g_we       = r_ctrl.g_we;
    assign o_q_we       = r_ctrl.q_we;
    assign o_b_we       = r_ctrl.b_we;
    assign o_a_we       = r_ctrl.a_we;
    assign o_y_we       = r_ctrl.y_we;
    assign o_x_we       = r_ctrl.x_we;
    assign o_z_we       = r_ctrl.z_we;
    assign o_mem_we     = r_ctrl.mem_we;
    assign o_busy       = r_ctrl.busy;
    assign o_instr_done = r_ctrl.instr_done;

endmodule

// File: tb/tb_agc_sequencer.sv
// tb_agc_sequencer: directed program through every opcode, checked each cycle
// against an instruction-level model plus hand-computed literal expectations.
module tb_agc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        accSign = 1'b0;
    logic        accZero = 1'b0;
    logic [15:0] memData;
    logic [11:0] pcAddr;
    logic [2:0]  aluOp;
    logic [1:0]  maddrMux, aMux, xMux, yMux, zMux, qMux;
    logic        lpMux, bMux, lpWe, gWe, qWe, bWe, aWe, yWe, xWe, zWe, memWe;
    logic        busy, instrDone;

    logic [15:0] memModel [0:4095];
    int          assertCount = 0;
    int          failCount = 0;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] maddr_mux, a_mux, x_mux, y_mux, z_mux, q_mux;
        logic       lp_mux, b_mux, lp_we, g_we, q_we, b_we, a_we, y_we, x_we, z_we, mem_we;
        logic       busy, instr_done;
    } ctrl_t;

    ctrl_t ctrlTab [0:7][0:3];
    int    execLen [0:7] = '{1, 3, 1, 4, 3, 1, 4, 4};
    ctrl_t dutCtrl;

    always #5 clk = ~clk;

    assign memData = memModel[pcAddr];
    assign dutCtrl = {aluOp, maddrMux, aMux, xMux, yMux, zMux, qMux, lpMux, bMux,
                      lpWe, gWe, qWe, bWe, aWe, yWe, xWe, zWe, memWe, busy, instrDone};

    agc_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_mem_data(memData),
        .i_acc_sign(accSign), .i_acc_zero(accZero),
        .o_pc_addr(pcAddr), .o_alu_op(aluOp), .o_maddr_mux(maddrMux),
        .o_a_mux(aMux), .o_x_mux(xMux), .o_y_mux(yMux), .o_z_mux(zMux), .o_q_mux(qMux),
        .o_lp_mux(lpMux), .o_b_mux(bMux), .o_lp_we(lpWe), .o_g_we(gWe), .o_q_we(qWe),
        .o_b_we(bWe), .o_a_we(aWe), .o_y_we(yWe), .o_x_we(xWe), .o_z_we(zWe),
        .o_mem_we(memWe), .o_busy(busy), .o_instr_done(instrDone)
    );

    // Model state: idle flag, cycle number within the instruction (0=F0, 1=F1, 2..=exec)
    bit          mIdle = 1'b1;
    int          mK = 0;
    logic [11:0] mPc = 12'o2000;
    logic [15:0] mIr = '0;
    bit          checkEn = 1'b0;
    int          mOp;
    int          mSkip;

    assign mOp   = int'(mIr[14:12]);
    assign mSkip = (accSign ? 2 : 0) + (accZero ? 1 : 0);

    initial begin
        for (int o = 0; o < 8; o++)
            for (int e = 0; e < 4; e++)
                ctrlTab[o][e] = '0;
        ctrlTab[1][0].maddr_mux = 2'd1;
        ctrlTab[1][1].a_we      = 1'b1;
        ctrlTab[3][0].maddr_mux = 2'd1;
        ctrlTab[3][1].g_we      = 1'b1;
        ctrlTab[3][2].maddr_mux = 2'd1;
        ctrlTab[3][2].mem_we    = 1'b1;
        ctrlTab[3][3].a_we      = 1'b1;
        ctrlTab[3][3].a_mux     = 2'd3;
        ctrlTab[4][0].maddr_mux = 2'd1;
        ctrlTab[4][1].a_we      = 1'b1;
        ctrlTab[4][2].a_we      = 1'b1;
        ctrlTab[4][2].a_mux     = 2'd2;
        ctrlTab[5][0].maddr_mux = 2'd1;
        ctrlTab[5][0].mem_we    = 1'b1;
        for (int o = 6; o < 8; o++) begin
            ctrlTab[o][0].maddr_mux = 2'd1;
            ctrlTab[o][1].x_we      = 1'b1;
            ctrlTab[o][1].x_mux     = 2'd3;
            ctrlTab[o][1].y_we      = 1'b1;
            ctrlTab[o][3].a_we      = 1'b1;
            ctrlTab[o][3].a_mux     = 2'd1;
        end
        ctrlTab[7][2].alu_op = 3'd1;
    end

    always @(posedge clk) begin
        if (reset) begin
            mIdle   <= 1'b1;
            mK      <= 0;
            mPc     <= 12'o2000;
            mIr     <= '0;
            checkEn <= 1'b1;
        end else if (mIdle) begin
            if (run) begin
                mIdle <= 1'b0;
                mK    <= 0;
            end
        end else if (mK == 0) begin
            mK <= 1;
        end else if (mK == 1) begin
            mIr <= memModel[mPc];
            mK  <= 2;
        end else if (mK - 2 == execLen[mOp] - 1) begin
            if (mOp == 0)      mPc <= mIr[11:0];
            else if (mOp == 1) mPc <= 12'((int'(mPc) + 1 + mSkip) % 4096);
            else               mPc <= 12'((int'(mPc) + 1) % 4096);
            if (run) mK <= 0;
            else     mIdle <= 1'b1;
        end else begin
            mK <= mK + 1;
        end
    end

    function automatic ctrl_t expectedCtrl();
        ctrl_t c;
        c = '0;
        if (!mIdle) begin
            if (mK >= 2) begin
                c            = ctrlTab[mOp][mK-2];
                c.instr_done = (mK - 2 == execLen[mOp] - 1);
            end
            if (mK == 1) c.b_we = 1'b1;
            c.busy = 1'b1;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            assertCount++;
            if (dutCtrl !== expectedCtrl()) begin
                failCount++;
                $display("[TB] FAIL ctrlWord at %0t: got %h expected %h", $time, dutCtrl, expectedCtrl());
            end
            assertCount++;
            if (pcAddr !== mPc) begin
                failCount++;
                $display("[TB] FAIL pcTrack at %0t: got %0d expected %0d", $time, pcAddr, mPc);
            end
            assertCount++;
            if (memWe && aWe) begin
                failCount++;
                $display("[TB] FAIL memWeWithAWe at %0t: got 1 expected 0", $time);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Run one instruction from IDLE (or from F0 if already started) and log event cycles.
    task automatic applyStimulus(input bit sgn, input bit zro, input bit started,
                                 output int aweCyc, output int aweMux, output int gCyc,
                                 output int memCyc, output int andCyc, output int doneCnt);
        int cyc;
        aweCyc = 0; aweMux = 0; gCyc = 0; memCyc = 0; andCyc = 0; doneCnt = 0;
        accSign = sgn;
        accZero = zro;
        if (!started) begin
            run = 1'b1;
            @(negedge clk);
        end
        run = 1'b0;
        cyc = 1;
        while (busy && cyc <= 12) begin
            if (aWe && aweCyc == 0) begin
                aweCyc = cyc;
                aweMux = int'(aMux);
            end
            if (gWe && gCyc == 0)           gCyc = cyc;
            if (memWe && memCyc == 0)       memCyc = cyc;
            if (aluOp == 3'd1 && andCyc == 0) andCyc = cyc;
            if (instrDone)                  doneCnt++;
            @(negedge clk);
            cyc++;
        end
        checkOutput("instrTimeout", int'(busy), 0);
    endtask

    initial begin
        int aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt;
        int sawAwe;
        for (int i = 0; i < 4096; i++) memModel[i] = 16'h2000;
        memModel[1024] = 16'h0040;
        memModel[64]   = 16'h6080;
        memModel[65]   = 16'h1081;
        memModel[66]   = 16'h1081;
        memModel[68]   = 16'h1081;
        memModel[71]   = 16'h1081;
        memModel[75]   = 16'h3082;
        memModel[76]   = 16'h4083;
        memModel[77]   = 16'h7084;
        memModel[79]   = 16'h0FFF;
        memModel[4095] = 16'h5085;
        memModel[0]    = 16'h6086;

        reset = 1'b1;
        run   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("resetPc", int'(pcAddr), 1024);
            checkOutput("resetOutputs", int'(dutCtrl), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        checkOutput("f0Busy", int'(busy), 1);
        checkOutput("f0Maddr", int'(maddrMux), 0);

        applyStimulus(1'b0, 1'b0, 1'b1, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("tcPc", int'(pcAddr), 64);
        checkOutput("tcDone", doneCnt, 1);
        checkOutput("tcNoWrites", aweCyc + gCyc + memCyc, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("adAweCycle", aweCyc, 6);
        checkOutput("adAweMux", aweMux, 1);
        checkOutput("adPc", int'(pcAddr), 65);

        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("ccsPosPc", int'(pcAddr), 66);
        applyStimulus(1'b0, 1'b1, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("ccsPosZeroPc", int'(pcAddr), 68);
        applyStimulus(1'b1, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("ccsNegPc", int'(pcAddr), 71);
        applyStimulus(1'b1, 1'b1, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("ccsNegZeroPc", int'(pcAddr), 75);

        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("xchGCycle", gCyc, 4);
        checkOutput("xchMemCycle", memCyc, 5);
        checkOutput("xchAweCycle", aweCyc, 6);
        checkOutput("xchAweMux", aweMux, 3);

        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("csPc", int'(pcAddr), 77);
        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("maskAndCycle", andCyc, 5);
        checkOutput("maskPc", int'(pcAddr), 78);
        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("indexPc", int'(pcAddr), 79);
        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("tcHighPc", int'(pcAddr), 4095);
        applyStimulus(1'b0, 1'b0, 1'b0, aweCyc, aweMux, gCyc, memCyc, andCyc, doneCnt);
        checkOutput("tsMemCycle", memCyc, 3);
        checkOutput("tsWrapPc", int'(pcAddr), 0);

        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("adE1XWe", int'(xWe), 1);
        reset = 1'b1;
        sawAwe = 0;
        repeat (5) begin
            @(negedge clk);
            if (aWe) sawAwe = 1;
        end
        checkOutput("resetMidPc", int'(pcAddr), 1024);
        checkOutput("resetMidIdle", int'(busy), 0);
        checkOutput("resetMidNoAwe", sawAwe, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
